// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode/writeback bus of the scoreboarded register file.
interface regfile_sb_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ra1;
    logic [ADDR_W-1:0] ra2;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [WIDTH-1:0]  wd3;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              flush;
    logic              busy1;
    logic              busy2;
    logic              waw;
    logic [ADDR_W:0]   pend_count;

    modport master (
        output ra1, ra2, we3, wa3, wd3, issue, issue_addr, flush,
        input  rd1, rd2, busy1, busy2, waw, pend_count
    );

    modport slave (
        input  ra1, ra2, we3, wa3, wd3, issue, issue_addr, flush,
        output rd1, rd2, busy1, busy2, waw, pend_count
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with write-to-read bypass and a
// pending-write scoreboard that tracks destinations in flight.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             wr_ok, issue_ok;
    logic             z1, z2, byp1, byp2;

    assign wr_ok    = bus.we3 && !((ZERO_REG != 0) && (bus.wa3 == '0));
    assign issue_ok = bus.issue && !((ZERO_REG != 0) && (bus.issue_addr == '0));
    assign z1       = (ZERO_REG != 0) && (bus.ra1 == '0);
    assign z2       = (ZERO_REG != 0) && (bus.ra2 == '0);
    assign byp1     = (BYPASS != 0) && bus.we3 && (bus.wa3 == bus.ra1);
    assign byp2     = (BYPASS != 0) && bus.we3 && (bus.wa3 == bus.ra2);

    assign bus.rd1   = z1 ? '0 : byp1 ? bus.wd3 : rf_q[bus.ra1];
    assign bus.rd2   = z2 ? '0 : byp2 ? bus.wd3 : rf_q[bus.ra2];
    assign bus.busy1 = !z1 && pend_q[bus.ra1] && !byp1;
    assign bus.busy2 = !z2 && pend_q[bus.ra2] && !byp2;
    assign bus.waw   = bus.issue && !bus.flush && pend_q[bus.issue_addr];
    assign bus.pend_count = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (wr_ok) begin
            rf_q[bus.wa3] <= bus.wd3;
        end
    end

    // issue is applied after the writeback clear so a new producer wins
    always_comb begin
        pend_d = pend_q;
        if (bus.flush) begin
            pend_d = '0;
        end else begin
            if (bus.we3) pend_d[bus.wa3] = 1'b0;
            if (issue_ok) pend_d[bus.issue_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench; driver queues expectations from an
// array-based model, a negedge monitor pops and compares.
module tb_regfile_sb;
    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        waw;
        logic [5:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [31:0] m_rf [32];
    bit m_pend [32];

    regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) bus ();
    regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd1", bus.rd1, e.rd1);
            chk("rd2", bus.rd2, e.rd2);
            chk("busy1", 32'(bus.busy1), 32'(e.b1));
            chk("busy2", 32'(bus.busy2), 32'(e.b2));
            chk("waw", 32'(bus.waw), 32'(e.waw));
            chk("pend_count", 32'(bus.pend_count), 32'(e.cnt));
        end
    end

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.we3 && bus.wa3 == a) return bus.wd3;
        return m_rf[a];
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
        e.rd1 = m_read(bus.ra1);
        e.rd2 = m_read(bus.ra2);
        e.b1  = bus.ra1 != 0 && m_pend[bus.ra1] && !(bus.we3 && bus.wa3 == bus.ra1);
        e.b2  = bus.ra2 != 0 && m_pend[bus.ra2] && !(bus.we3 && bus.wa3 == bus.ra2);
        e.waw = bus.issue && !bus.flush && m_pend[bus.issue_addr];
        e.cnt = 6'(n);
        return e;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'h0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input bit iss, input logic [4:0] ia, input bit fl);
        bus.we3 = we; bus.wa3 = wa; bus.wd3 = wd;
        bus.ra1 = a1; bus.ra2 = a2;
        bus.issue = iss; bus.issue_addr = ia; bus.flush = fl;
        q.push_back(m_expect());
        @(posedge clk);
        if (we && wa != 0) m_rf[wa] = wd;
        if (fl) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (we) m_pend[wa] = 1'b0;
            if (iss && ia != 0) m_pend[ia] = 1'b1;
        end
        #2;
    endtask

    task automatic reset_step(input logic [4:0] a1, input logic [4:0] a2);
        bus.we3 = 1'b0; bus.issue = 1'b0; bus.flush = 1'b0;
        bus.ra1 = a1; bus.ra2 = a2;
        rst_n = 1'b0;
        m_clear();
        q.push_back(m_expect());
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic rnd_step(input int span);
        step(($urandom_range(0, 1) == 1), 5'($urandom_range(0, span)), $urandom,
             5'($urandom_range(0, span)), 5'($urandom_range(0, span)),
             ($urandom_range(0, 1) == 1), 5'($urandom_range(0, span)),
             ($urandom_range(0, 15) == 0));
    endtask

    initial begin
        bus.we3 = 0; bus.wa3 = 0; bus.wd3 = 0; bus.ra1 = 0; bus.ra2 = 0;
        bus.issue = 0; bus.issue_addr = 0; bus.flush = 0;
        m_clear();
        @(posedge clk);
        #2;
        reset_step(5'd5, 5'd7);
        // bypass of a fresh write, then read it back from the array
        step(1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd3, 0, 5'd0, 0);
        step(0, 5'd0, 32'h0, 5'd5, 5'd5, 0, 5'd0, 0);
        // claim r7, observe busy, clear via writeback with bypass
        step(0, 5'd0, 32'h0, 5'd1, 5'd7, 1, 5'd7, 0);
        step(0, 5'd0, 32'h0, 5'd1, 5'd7, 0, 5'd0, 0);
        step(1, 5'd7, 32'h77, 5'd7, 5'd7, 0, 5'd0, 0);
        step(0, 5'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0, 0);
        // issue and writeback to pending r7 on the same edge
        step(0, 5'd0, 32'h0, 5'd7, 5'd7, 1, 5'd7, 0);
        step(1, 5'd7, 32'h99, 5'd7, 5'd7, 1, 5'd7, 0);
        step(0, 5'd0, 32'h0, 5'd7, 5'd2, 0, 5'd0, 0);
        // flush wins over a simultaneous issue
        step(0, 5'd0, 32'h0, 5'd1, 5'd2, 1, 5'd1, 0);
        step(0, 5'd0, 32'h0, 5'd1, 5'd2, 1, 5'd2, 0);
        step(0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 5'd3, 0);
        step(0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 5'd4, 1);
        step(0, 5'd0, 32'h0, 5'd4, 5'd1, 0, 5'd0, 0);
        // register zero ignores writes and claims
        step(1, 5'd0, 32'h1234, 5'd0, 5'd0, 1, 5'd0, 0);
        step(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < 300; i++) rnd_step(7);
        for (int i = 0; i < 200; i++) rnd_step(31);
        for (int i = 0; i < 40; i++) step(0, 5'd0, 32'h0, 5'($urandom), 5'($urandom), 1, 5'($urandom), 0);
        reset_step(5'd5, 5'd9);
        for (int i = 0; i < 100; i++) rnd_step(7);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
